// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the fetch (I) and load/store (D) ports.
// One access in flight at a time: IDLE -> ACC -> RESP, so at most one access per 3 cycles.
module mem_port_arbiter #(
    parameter int unsigned PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StIAcc,
        StIResp,
        StDAcc,
        StDResp
    } state_e;

    typedef enum logic {
        GrantI,
        GrantD
    } grant_e;

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        grant_i, grant_d;

    // Contention: fixed D priority, or round-robin away from the last winner.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if ((PRIORITY != 0) || (last_grant_q == GrantI)) begin
                grant_d = 1'b1;
            end else begin
                grant_i = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;

        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d       = StDAcc;
                    last_grant_d  = GrantD;
                    mem_we_d      = d_we;
                    mem_addr_d    = d_addr;
                    mem_data_in_d = d_wdata;
                end else if (grant_i) begin
                    state_d      = StIAcc;
                    last_grant_d = GrantI;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                end
            end
            StIAcc: begin
                // Memory samples at the end of this cycle; write enable must not linger.
                state_d  = StIResp;
                mem_we_d = 1'b0;
            end
            StDAcc: begin
                state_d  = StDResp;
                mem_we_d = 1'b0;
            end
            StIResp: state_d = StIdle;
            StDResp: state_d = StIdle;
            default: begin
                state_d  = StIdle;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_grant_q  <= GrantD;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_data_in_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    // Read data is a straight pass of the memory's registered output.
    assign i_rdata     = mem_data_out;
    assign d_rdata     = mem_data_out;
    assign i_ready     = (state_q == StIResp);
    assign d_ready     = (state_q == StDResp);
    assign busy        = (state_q != StIdle);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;

    a_we_one_cycle: assert property (@(posedge clk) disable iff (rst) mem_we |=> !mem_we);
    a_ready_excl:   assert property (@(posedge clk) !(i_ready && d_ready));
    a_we_only_d:    assert property (@(posedge clk) mem_we |-> (state_q == StDAcc));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and D-priority instances side by side, each with its
// own memory, checked every cycle against a transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int NI = 2;
    localparam logic [31:0] BootWord = 32'h2008_0005;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst;
    logic [NI-1:0]        i_req, i_ready, d_req, d_we, d_ready, mem_we, busy;
    logic [NI-1:0][31:0]  i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [NI-1:0][31:0]  mem_addr, mem_data_in, mem_data_out;

    mem_port_arbiter #(.PRIORITY(0)) u_dut_rr (
        .clk(clk), .rst(rst[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ready(i_ready[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_data_in(mem_data_in[0]),
        .mem_data_out(mem_data_out[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.PRIORITY(1)) u_dut_pri (
        .clk(clk), .rst(rst[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ready(i_ready[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_data_in(mem_data_in[1]),
        .mem_data_out(mem_data_out[1]), .busy(busy[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] preload_word(input int w);
        logic [31:0] v;
        v = 32'hA500_0000 | 32'(w);
        if (w == 0) v = BootWord;
        return v;
    endfunction

    // Unified memory: no reset, 1-cycle read latency, read-before-write.
    logic [31:0] mem [NI][1024];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < NI; k++)
                for (int w = 0; w < 1024; w++) mem[k][w] <= preload_word(w);
            mem_loaded <= 1'b1;
        end else begin
            for (int k = 0; k < NI; k++) begin
                mem_data_out[k] <= mem[k][mem_addr[k][11:2]];
                if (mem_we[k]) mem[k][mem_addr[k][11:2]] <= mem_data_in[k];
            end
        end
    end

    // Reference model: tracks at most one transaction per instance by the edge it was granted.
    // Grant at edge g -> memory access at edge g+1 -> ready in the cycle after g+1 -> next
    // request sample at edge g+3.
    logic [31:0]  ref_mem [NI][1024];
    int unsigned  ecnt = 0;
    int unsigned  nxt_sample [NI];
    int unsigned  t_edge [NI];
    bit           t_valid [NI], t_is_d [NI], t_we [NI], last_was_d [NI];
    logic [31:0]  t_addr [NI], t_wdata [NI], t_rdata [NI];
    bit           m_i_rdy [NI], m_d_rdy [NI], m_busy [NI], m_we [NI];
    logic [31:0]  m_addr [NI], m_din [NI], m_rdata [NI];
    bit           pick_d;

    always @(posedge clk) begin
        ecnt++;
        for (int k = 0; k < NI; k++) begin
            if (ecnt == 1) begin
                for (int w = 0; w < 1024; w++) ref_mem[k][w] = preload_word(w);
                t_valid[k] = 1'b0;
            end
            m_i_rdy[k] = 1'b0;
            m_d_rdy[k] = 1'b0;
            m_busy[k]  = 1'b0;
            m_we[k]    = 1'b0;
            if (t_valid[k] && ecnt == t_edge[k] + 1) begin
                t_rdata[k] = ref_mem[k][t_addr[k][11:2]];
                if (t_we[k]) ref_mem[k][t_addr[k][11:2]] = t_wdata[k];
            end
            if (rst[k]) begin
                t_valid[k]    = 1'b0;
                last_was_d[k] = 1'b1;
                nxt_sample[k] = ecnt + 1;
                m_addr[k]     = 32'h0;
                m_din[k]      = 32'h0;
            end else begin
                if (t_valid[k] && ecnt == t_edge[k] + 1) begin
                    m_busy[k]  = 1'b1;
                    m_d_rdy[k] = t_is_d[k];
                    m_i_rdy[k] = !t_is_d[k];
                    m_rdata[k] = t_rdata[k];
                end else if (t_valid[k] && ecnt == t_edge[k] + 2) begin
                    t_valid[k] = 1'b0;
                end
                if (!t_valid[k] && ecnt >= nxt_sample[k] && (i_req[k] || d_req[k])) begin
                    pick_d = d_req[k] && (!i_req[k] || k == 1 || !last_was_d[k]);
                    t_valid[k]    = 1'b1;
                    t_is_d[k]     = pick_d;
                    t_edge[k]     = ecnt;
                    nxt_sample[k] = ecnt + 3;
                    last_was_d[k] = pick_d;
                    t_we[k]       = pick_d && d_we[k];
                    t_addr[k]     = pick_d ? d_addr[k] : i_addr[k];
                    t_wdata[k]    = d_wdata[k];
                    m_busy[k]     = 1'b1;
                    m_we[k]       = t_we[k];
                    m_addr[k]     = t_addr[k];
                    if (pick_d) m_din[k] = d_wdata[k];
                end
            end
        end
    end

    int we_cnt [NI] = '{0, 0};
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("i_ready[%0d]", k), 32'(i_ready[k]), 32'(m_i_rdy[k]));
            check_eq($sformatf("d_ready[%0d]", k), 32'(d_ready[k]), 32'(m_d_rdy[k]));
            check_eq($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
            check_eq($sformatf("mem_we[%0d]", k), 32'(mem_we[k]), 32'(m_we[k]));
            check_eq($sformatf("mem_addr[%0d]", k), mem_addr[k], m_addr[k]);
            if (m_we[k]) check_eq($sformatf("mem_data_in[%0d]", k), mem_data_in[k], m_din[k]);
            if (m_i_rdy[k]) check_eq($sformatf("i_rdata[%0d]", k), i_rdata[k], m_rdata[k]);
            if (m_d_rdy[k]) check_eq($sformatf("d_rdata[%0d]", k), d_rdata[k], m_rdata[k]);
            if (mem_we[k] === 1'b1) we_cnt[k]++;
        end
    end

    task automatic do_txn(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bit seen;
        seen  = 1'b0;
        lat   = 0;
        rdata = 32'h0;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (is_d ? d_ready[k] : i_ready[k]) begin
                seen  = 1'b1;
                rdata = is_d ? d_rdata[k] : i_rdata[k];
            end
        end
        if (is_d) d_req[k] = 1'b0;
        else i_req[k] = 1'b0;
        check_eq("txn_completes", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic drive_random();
        for (int k = 0; k < NI; k++) begin
            rst[k] = ($urandom_range(0, 299) == 0);
            if (i_ready[k]) begin
                i_req[k] = ($urandom_range(0, 1) == 1); i_addr[k] = rand_addr();
            end else if (!i_req[k]) begin
                if ($urandom_range(0, 2) == 0) begin i_req[k] = 1'b1; i_addr[k] = rand_addr(); end
            end else if ($urandom_range(0, 19) == 0) begin
                i_req[k] = 1'b0;
            end
            if (d_ready[k] || (!d_req[k] && $urandom_range(0, 2) == 0)) begin
                d_req[k]   = d_ready[k] ? ($urandom_range(0, 1) == 1) : 1'b1;
                d_we[k]    = ($urandom_range(0, 1) == 1);
                d_addr[k]  = rand_addr();
                d_wdata[k] = $urandom;
            end else if (d_req[k] && $urandom_range(0, 19) == 0) begin
                d_req[k] = 1'b0;
            end
        end
    endtask

    int          ev_n [NI];
    int          ev_port [NI][8];
    int          ev_cyc [NI][8];
    logic [31:0] ev_data [NI][8];
    logic [31:0] rd;
    int          lat, w0, pulses;
    bit          seen;

    initial begin
        rst = '1; i_req = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < NI; k++) ev_n[k] = 0;

        // Both ports requesting straight out of reset: RR alternates I,D; priority keeps D.
        i_req = '1; d_req = '1;
        d_addr[0] = 32'h100; d_addr[1] = 32'h100;
        repeat (3) @(negedge clk);
        rst = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check_eq($sformatf("ready_excl[%0d]", k), 32'(i_ready[k] & d_ready[k]), 32'd0);
                if ((i_ready[k] || d_ready[k]) && ev_n[k] < 8) begin
                    ev_port[k][ev_n[k]] = d_ready[k] ? 1 : 0;
                    ev_cyc[k][ev_n[k]]  = n;
                    ev_data[k][ev_n[k]] = i_rdata[k];
                    ev_n[k]++;
                end
            end
        end
        d_req = '0; i_req[0] = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("grant_count[%0d]", k), 32'(ev_n[k]), 32'd4);
            for (int j = 0; j < 4; j++) begin
                check_eq($sformatf("grant_order[%0d][%0d]", k, j), 32'(ev_port[k][j]),
                         (k == 0) ? 32'(j % 2) : 32'd1);
                if (j > 0)
                    check_eq($sformatf("grant_gap[%0d][%0d]", k, j),
                             32'(ev_cyc[k][j] - ev_cyc[k][j-1]), 32'd3);
            end
        end
        check_eq("rr_fetch0_word", ev_data[0][0], BootWord);
        check_eq("rr_fetch1_word", ev_data[0][2], BootWord);

        // Priority instance: I only wins once D drops.
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (i_ready[1]) begin seen = 1'b1; rd = i_rdata[1]; end
        end
        i_req[1] = 1'b0;
        check_eq("pri_fetch_seen", 32'(seen), 32'd1);
        check_eq("pri_fetch_word", rd, BootWord);
        repeat (2) @(negedge clk);

        // Store then load on the RR instance.
        w0 = we_cnt[0];
        do_txn(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, rd, lat);
        check_eq("store_we_cycles", 32'(we_cnt[0] - w0), 32'd1);
        check_eq("store_latency", 32'(lat), 32'd2);
        do_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        check_eq("load_back", rd, 32'hDEAD_BEEF);
        check_eq("load_latency", 32'(lat), 32'd2);
        check_eq("load_no_we", 32'(we_cnt[0] - w0), 32'd1);

        // Read-before-write on a store, then the new value on a load.
        do_txn(1, 1'b1, 1'b1, 32'h44, 32'h1111_1111, rd, lat);
        check_eq("store_old_word", rd, 32'hA500_0011);
        do_txn(1, 1'b1, 1'b0, 32'h44, 32'h0, rd, lat);
        check_eq("load_new_word", rd, 32'h1111_1111);

        // One-cycle D request pulse still completes exactly once.
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h8;
        @(negedge clk);
        d_req[0] = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            if (d_ready[0]) pulses++;
            @(negedge clk);
        end
        check_eq("pulse_one_ready", 32'(pulses), 32'd1);
        check_eq("pulse_idle_after", 32'(busy[0]), 32'd0);

        // Reset during I_RESP.
        i_req[0] = 1'b1; i_addr[0] = 32'h4;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = i_ready[0];
        end
        check_eq("rst_fetch_seen", 32'(seen), 32'd1);
        i_req[0] = 1'b0; rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_i_ready", 32'(i_ready[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        @(negedge clk);

        // Reset coinciding with a store's access cycle still commits the write.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h80; d_wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("acc_we_high", 32'(mem_we[0]), 32'd1);
        d_req[0] = 1'b0; rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_acc_no_ready", 32'(d_ready[0]), 32'd0);
        check_eq("rst_acc_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        @(negedge clk);
        do_txn(0, 1'b1, 1'b0, 32'h80, 32'h0, rd, lat);
        check_eq("rst_store_committed", rd, 32'hCAFE_F00D);

        // Randomized traffic, including occasional resets, against the model.
        repeat (4000) begin
            @(negedge clk);
            drive_random();
        end
        rst = '0; i_req = '0; d_req = '0;
        repeat (6) @(negedge clk);
        check_eq("final_idle_rr", 32'(busy[0]), 32'd0);
        check_eq("final_idle_pri", 32'(busy[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
